// File: rtl/dcm_ctl.sv
// -----------------------------------------------------------------------------
// dcm_ctl -- DCM reset / lock supervisor
//
// Purpose:
//   Sequences a DCM through reset, lock acquisition and a settle period.
//   It raises `ready` only after `locked` has been stable for SETTLE_CYCLES.
//   Lock timeouts and lock losses are counted in a saturating failure counter.
//
//   State encoding, visible on the `state` port:
//     RESET=0, WAIT_LOCK=1, SETTLE=2, RUN=3
//
// Parameters:
//   RST_CYCLES    (3..255)     cycles dcm_rst is held high per reset pulse
//   LOCK_TIMEOUT  (1..65535)   cycles allowed in WAIT_LOCK before a retry
//   SETTLE_CYCLES (1..255)     consecutive locked cycles required before RUN
//
// Optional feature:
//   DCM_CTL_STATUS_EN  When defined, status[1] (CLKIN stopped) or
//                      status[2] (CLKFX stopped) seen in SETTLE or RUN is
//                      treated as a lock loss. When undefined, the status
//                      port is present but has no effect.
//
// Ports:
//   clk       in   free-running reference clock (also the DCM CLKIN)
//   rst       in   synchronous, active-high reset
//   locked    in   DCM LOCKED, already synchronous to clk
//   status    in   [7:0] DCM STATUS bus
//   relock    in   single-cycle request to force a DCM reset sequence
//   dcm_rst   out  registered drive to the DCM RST pin
//   ready     out  high while the DCM outputs are usable (RUN only)
//   state     out  [1:0] current state
//   fail_cnt  out  [7:0] saturating count of timeouts and lock losses
// -----------------------------------------------------------------------------
module dcm_ctl #(
    parameter int unsigned RST_CYCLES    = 3,
    parameter int unsigned LOCK_TIMEOUT  = 65535,
    parameter int unsigned SETTLE_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       locked,
    input  logic [7:0] status,
    input  logic       relock,
    output logic       dcm_rst,
    output logic       ready,
    output logic [1:0] state,
    output logic [7:0] fail_cnt
);

    typedef enum logic [1:0] {
        ST_RESET     = 2'd0,
        ST_WAIT_LOCK = 2'd1,
        ST_SETTLE    = 2'd2,
        ST_RUN       = 2'd3
    } state_e;

    // Terminal counts. Each counter runs from 0, so the last cycle is N-1.
    localparam logic [7:0]  RST_LAST     = 8'(RST_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_LAST = 16'(LOCK_TIMEOUT - 1);
    localparam logic [7:0]  SETTLE_LAST  = 8'(SETTLE_CYCLES - 1);

    state_e      state_q, state_d;
    logic [7:0]  rst_cnt_q, rst_cnt_d;
    logic [15:0] to_cnt_q, to_cnt_d;
    logic [7:0]  settle_cnt_q, settle_cnt_d;
    logic [7:0]  fail_cnt_q, fail_cnt_d;
    logic        dcm_rst_q, dcm_rst_d;
    logic        ready_q, ready_d;
    logic        fail_evt;
    logic        clk_stopped;

`ifdef DCM_CTL_STATUS_EN
    assign clk_stopped = status[1] | status[2];
    // Remaining status bits have no meaning here; this sink has no load.
    logic unused_status;
    assign unused_status = ^{status[7:3], status[0]};
`else
    assign clk_stopped = 1'b0;
    // Status is ignored in this build; this sink has no load.
    logic unused_status;
    assign unused_status = ^status;
`endif

    // -------------------------------------------------------------------------
    // State register: all flops, including the registered outputs.
    // -------------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments only, so every
    // flop samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RESET;
            rst_cnt_q    <= '0;
            to_cnt_q     <= '0;
            settle_cnt_q <= '0;
            fail_cnt_q   <= '0;
            dcm_rst_q    <= 1'b1;
            ready_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            rst_cnt_q    <= rst_cnt_d;
            to_cnt_q     <= to_cnt_d;
            settle_cnt_q <= settle_cnt_d;
            fail_cnt_q   <= fail_cnt_d;
            dcm_rst_q    <= dcm_rst_d;
            ready_q      <= ready_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and counter logic.
    // -------------------------------------------------------------------------
    // NOTE: every variable gets a default at the top of the block, so no path
    // leaves a value unassigned and no latch is inferred.
    always_comb begin
        state_d      = state_q;
        rst_cnt_d    = rst_cnt_q;
        to_cnt_d     = to_cnt_q;
        settle_cnt_d = settle_cnt_q;
        fail_cnt_d   = fail_cnt_q;
        fail_evt     = 1'b0;

        unique case (state_q)
            // relock is deliberately not examined here.
            ST_RESET: begin
                if (rst_cnt_q == RST_LAST) begin
                    state_d = ST_WAIT_LOCK;
                end else begin
                    rst_cnt_d = rst_cnt_q + 8'd1;
                end
            end

            // A timeout is a failure and outranks a relock on the same cycle.
            ST_WAIT_LOCK: begin
                if (!locked && (to_cnt_q == TIMEOUT_LAST)) begin
                    state_d  = ST_RESET;
                    fail_evt = 1'b1;
                end else if (relock) begin
                    state_d = ST_RESET;
                end else if (locked) begin
                    state_d = ST_SETTLE;
                end else begin
                    to_cnt_d = to_cnt_q + 16'd1;
                end
            end

            // Losing lock while settling is not a failure; just wait again.
            ST_SETTLE: begin
                if (clk_stopped) begin
                    state_d  = ST_RESET;
                    fail_evt = 1'b1;
                end else if (relock) begin
                    state_d = ST_RESET;
                end else if (!locked) begin
                    state_d = ST_WAIT_LOCK;
                end else if (settle_cnt_q == SETTLE_LAST) begin
                    state_d = ST_RUN;
                end else begin
                    settle_cnt_d = settle_cnt_q + 8'd1;
                end
            end

            // A lock loss outranks a coincident relock so that it is counted.
            ST_RUN: begin
                if (!locked || clk_stopped) begin
                    state_d  = ST_RESET;
                    fail_evt = 1'b1;
                end else if (relock) begin
                    state_d = ST_RESET;
                end
            end
        endcase

        // Every counter restarts from zero on entry to any state.
        if (state_d != state_q) begin
            rst_cnt_d    = '0;
            to_cnt_d     = '0;
            settle_cnt_d = '0;
        end

        if (fail_evt && (fail_cnt_q != 8'hFF)) begin
            fail_cnt_d = fail_cnt_q + 8'd1;
        end
    end

    // -------------------------------------------------------------------------
    // Output logic.
    // Outputs are decoded from the next state and then registered. As a
    // result, dcm_rst rises on the same edge that ready falls.
    // -------------------------------------------------------------------------
    always_comb begin
        dcm_rst_d = (state_d == ST_RESET);
        ready_d   = (state_d == ST_RUN);
    end

    assign dcm_rst  = dcm_rst_q;
    assign ready    = ready_q;
    assign state    = state_q;
    assign fail_cnt = fail_cnt_q;

endmodule

// File: tb/tb_dcm_ctl.sv
// -----------------------------------------------------------------------------
// tb_dcm_ctl -- self-checking bench for dcm_ctl
//
// Instance u_dut uses the default parameters.
// Instance u_dut_fast uses LOCK_TIMEOUT=4 so that fail_cnt saturation is
// reachable in a short run.
//
// Each test task builds a per-cycle stimulus table. As each row is driven,
// the expected outputs are pushed to a scoreboard queue. One cycle later,
// #1 after the edge, the expectation is popped and compared.
// -----------------------------------------------------------------------------
module tb_dcm_ctl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    // Default-parameter instance.
    logic       rst_a, locked_a, relock_a;
    logic [7:0] status_a;
    logic       dcm_rst_a, ready_a;
    logic [1:0] state_a;
    logic [7:0] fail_cnt_a;

    dcm_ctl u_dut (
        .clk      (clk),
        .rst      (rst_a),
        .locked   (locked_a),
        .status   (status_a),
        .relock   (relock_a),
        .dcm_rst  (dcm_rst_a),
        .ready    (ready_a),
        .state    (state_a),
        .fail_cnt (fail_cnt_a)
    );

    // Short-timeout instance for the saturation scenario.
    logic       rst_b, locked_b, relock_b;
    logic [7:0] status_b;
    logic       dcm_rst_b, ready_b;
    logic [1:0] state_b;
    logic [7:0] fail_cnt_b;

    dcm_ctl #(.LOCK_TIMEOUT(4)) u_dut_fast (
        .clk      (clk),
        .rst      (rst_b),
        .locked   (locked_b),
        .status   (status_b),
        .relock   (relock_b),
        .dcm_rst  (dcm_rst_b),
        .ready    (ready_b),
        .state    (state_b),
        .fail_cnt (fail_cnt_b)
    );

    typedef struct packed {
        logic [1:0] state;
        logic       dcm_rst;
        logic       ready;
        logic [7:0] fail_cnt;
    } obs_t;

    typedef struct {
        logic       rst;
        logic       locked;
        logic       relock;
        logic [7:0] status;
        logic       chk;
        string      tag;
        logic [1:0] st;
        logic [7:0] fc;
    } vec_t;

    vec_t  stim_q[$];
    obs_t  exp_q[$];
    string tag_q[$];
    int    n_checks = 0;
    int    n_fail   = 0;

    // dcm_rst is high exactly in RESET, and ready is high exactly in RUN.
    function automatic obs_t mk(logic [1:0] s, logic [7:0] f);
        obs_t o;
        o.state    = s;
        o.dcm_rst  = (s == 2'd0);
        o.ready    = (s == 2'd3);
        o.fail_cnt = f;
        return o;
    endfunction

    function automatic obs_t obs_a();
        obs_t o;
        o.state    = state_a;
        o.dcm_rst  = dcm_rst_a;
        o.ready    = ready_a;
        o.fail_cnt = fail_cnt_a;
        return o;
    endfunction

    function automatic obs_t obs_b();
        obs_t o;
        o.state    = state_b;
        o.dcm_rst  = dcm_rst_b;
        o.ready    = ready_b;
        o.fail_cnt = fail_cnt_b;
        return o;
    endfunction

    function automatic string fmt(obs_t o);
        return $sformatf("state=%0d dcm_rst=%0b ready=%0b fail_cnt=%0d",
                         o.state, o.dcm_rst, o.ready, o.fail_cnt);
    endfunction

    function automatic void add(logic r, logic l, logic rl, logic [7:0] st,
                                logic chk, string tag, logic [1:0] s, logic [7:0] f);
        vec_t v;
        v.rst = r; v.locked = l; v.relock = rl; v.status = st;
        v.chk = chk; v.tag = tag; v.st = s; v.fc = f;
        stim_q.push_back(v);
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // -------------------------------------------------------------------------
    task automatic test_reset();
        for (int i = 0; i < 5; i++) add(1'b1, 1'b0, (i == 2), 8'h00, 1'b1, "reset_hold", 2'd0, 8'd0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "reset_count1", 2'd0, 8'd0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "reset_count2", 2'd0, 8'd0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "reset_to_wait", 2'd1, 8'd0);
        while (stim_q.size() > 0) begin
            vec_t v; obs_t e; obs_t got; string t;
            v = stim_q.pop_front();
            rst_a = v.rst; locked_a = v.locked; relock_a = v.relock; status_a = v.status;
            if (v.chk) begin exp_q.push_back(mk(v.st, v.fc)); tag_q.push_back(v.tag); end
            step();
            if (v.chk) begin
                e = exp_q.pop_front(); t = tag_q.pop_front(); got = obs_a();
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %s, expected %s", t, fmt(got), fmt(e));
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // The DUT has just entered WAIT_LOCK. That first cycle was already checked,
    // so 65534 further WAIT_LOCK cycles remain before the retry.
    task automatic test_timeout();
        for (int k = 1; k <= 65535; k++) begin
            if (k <= 65534) add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "wait_timeout", 2'd1, 8'd0);
            else            add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "timeout_retry", 2'd0, 8'd1);
        end
        while (stim_q.size() > 0) begin
            vec_t v; obs_t e; obs_t got; string t;
            v = stim_q.pop_front();
            rst_a = v.rst; locked_a = v.locked; relock_a = v.relock; status_a = v.status;
            if (v.chk) begin exp_q.push_back(mk(v.st, v.fc)); tag_q.push_back(v.tag); end
            step();
            if (v.chk) begin
                e = exp_q.pop_front(); t = tag_q.pop_front(); got = obs_a();
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %s, expected %s", t, fmt(got), fmt(e));
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    task automatic test_lock_settle();
        add(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, "rst_clears_fail", 2'd0, 8'd0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "lk_reset1", 2'd0, 8'd0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "lk_reset2", 2'd0, 8'd0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "lk_wait_entry", 2'd1, 8'd0);
        for (int i = 0; i < 9; i++) add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "lk_waiting", 2'd1, 8'd0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, "lk_to_settle", 2'd2, 8'd0);
        for (int i = 1; i <= 16; i++)
            add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, (i < 16) ? "lk_settling" : "lk_to_run",
                (i < 16) ? 2'd2 : 2'd3, 8'd0);
        for (int i = 0; i < 3; i++) add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, "lk_run_hold", 2'd3, 8'd0);
        while (stim_q.size() > 0) begin
            vec_t v; obs_t e; obs_t got; string t;
            v = stim_q.pop_front();
            rst_a = v.rst; locked_a = v.locked; relock_a = v.relock; status_a = v.status;
            if (v.chk) begin exp_q.push_back(mk(v.st, v.fc)); tag_q.push_back(v.tag); end
            step();
            if (v.chk) begin
                e = exp_q.pop_front(); t = tag_q.pop_front(); got = obs_a();
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %s, expected %s", t, fmt(got), fmt(e));
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // This scenario starts in RUN. A relock forces RESET, and a relock during
    // RESET must be ignored. A one-cycle lock drop at settle count 8 must
    // restart the full settle period.
    task automatic test_settle_glitch();
        add(1'b0, 1'b1, 1'b1, 8'h00, 1'b1, "run_relock", 2'd0, 8'd0);
        add(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, "reset_ignores_relock", 2'd0, 8'd0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "gl_reset2", 2'd0, 8'd0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "gl_to_wait", 2'd1, 8'd0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, "gl_to_settle", 2'd2, 8'd0);
        for (int i = 1; i <= 8; i++) add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, "gl_pre_glitch", 2'd2, 8'd0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "gl_drop_to_wait", 2'd1, 8'd0);
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, "gl_resettle", 2'd2, 8'd0);
        for (int i = 1; i <= 16; i++)
            add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, (i < 16) ? "gl_full_settle" : "gl_to_run",
                (i < 16) ? 2'd2 : 2'd3, 8'd0);
        while (stim_q.size() > 0) begin
            vec_t v; obs_t e; obs_t got; string t;
            v = stim_q.pop_front();
            rst_a = v.rst; locked_a = v.locked; relock_a = v.relock; status_a = v.status;
            if (v.chk) begin exp_q.push_back(mk(v.st, v.fc)); tag_q.push_back(v.tag); end
            step();
            if (v.chk) begin
                e = exp_q.pop_front(); t = tag_q.pop_front(); got = obs_a();
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %s, expected %s", t, fmt(got), fmt(e));
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // This scenario starts in RUN. A lock loss and a relock on the same cycle
    // count once. A relock in WAIT_LOCK adds nothing. The scenario ends back
    // in RUN.
    task automatic test_loss_relock();
        add(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, "loss_and_relock", 2'd0, 8'd1);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "loss_reset1", 2'd0, 8'd1);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "loss_reset2", 2'd0, 8'd1);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "loss_to_wait", 2'd1, 8'd1);
        add(1'b0, 1'b0, 1'b1, 8'h00, 1'b1, "wait_relock", 2'd0, 8'd1);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "wr_reset1", 2'd0, 8'd1);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "wr_reset2", 2'd0, 8'd1);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "wr_to_wait", 2'd1, 8'd1);
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, "wr_to_settle", 2'd2, 8'd1);
        for (int i = 1; i <= 16; i++)
            add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, (i < 16) ? "wr_settling" : "wr_to_run",
                (i < 16) ? 2'd2 : 2'd3, 8'd1);
        while (stim_q.size() > 0) begin
            vec_t v; obs_t e; obs_t got; string t;
            v = stim_q.pop_front();
            rst_a = v.rst; locked_a = v.locked; relock_a = v.relock; status_a = v.status;
            if (v.chk) begin exp_q.push_back(mk(v.st, v.fc)); tag_q.push_back(v.tag); end
            step();
            if (v.chk) begin
                e = exp_q.pop_front(); t = tag_q.pop_front(); got = obs_a();
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %s, expected %s", t, fmt(got), fmt(e));
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // This scenario starts in RUN with fail_cnt=1. A STATUS clock-stopped
    // pulse is applied, and its effect depends on the build configuration.
    task automatic test_status();
`ifdef DCM_CTL_STATUS_EN
        add(1'b0, 1'b1, 1'b0, 8'h02, 1'b1, "status_clkin_stop", 2'd0, 8'd2);
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, "status_reset_hold", 2'd0, 8'd2);
`else
        add(1'b0, 1'b1, 1'b0, 8'h02, 1'b1, "status_ignored_02", 2'd3, 8'd1);
        add(1'b0, 1'b1, 1'b0, 8'h04, 1'b1, "status_ignored_04", 2'd3, 8'd1);
        add(1'b0, 1'b1, 1'b0, 8'h00, 1'b1, "status_run_hold", 2'd3, 8'd1);
`endif
        while (stim_q.size() > 0) begin
            vec_t v; obs_t e; obs_t got; string t;
            v = stim_q.pop_front();
            rst_a = v.rst; locked_a = v.locked; relock_a = v.relock; status_a = v.status;
            if (v.chk) begin exp_q.push_back(mk(v.st, v.fc)); tag_q.push_back(v.tag); end
            step();
            if (v.chk) begin
                e = exp_q.pop_front(); t = tag_q.pop_front(); got = obs_a();
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %s, expected %s", t, fmt(got), fmt(e));
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    // With LOCK_TIMEOUT=4, each retry is 3 RESET cycles plus 4 WAIT_LOCK
    // cycles. After 300 retries fail_cnt must sit at 255, and an rst pulse
    // must clear it.
    task automatic test_saturate();
        add(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, "fast_reset", 2'd0, 8'd0);
        for (int r = 1; r <= 300; r++) begin
            for (int j = 0; j < 7; j++)
                add(1'b0, 1'b0, 1'b0, 8'h00, (j == 6), "sat_retry", 2'd0,
                    (r > 255) ? 8'd255 : 8'(r));
        end
        add(1'b1, 1'b0, 1'b0, 8'h00, 1'b1, "sat_clear", 2'd0, 8'd0);
        add(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, "sat_cleared_hold", 2'd0, 8'd0);
        while (stim_q.size() > 0) begin
            vec_t v; obs_t e; obs_t got; string t;
            v = stim_q.pop_front();
            rst_b = v.rst; locked_b = v.locked; relock_b = v.relock; status_b = v.status;
            if (v.chk) begin exp_q.push_back(mk(v.st, v.fc)); tag_q.push_back(v.tag); end
            step();
            if (v.chk) begin
                e = exp_q.pop_front(); t = tag_q.pop_front(); got = obs_b();
                n_checks++;
                if (got !== e) begin
                    n_fail++;
                    $display("FAIL %s: got %s, expected %s", t, fmt(got), fmt(e));
                end
            end
        end
    endtask

    // -------------------------------------------------------------------------
    initial begin
        rst_a = 1'b1; locked_a = 1'b0; relock_a = 1'b0; status_a = 8'h00;
        rst_b = 1'b1; locked_b = 1'b0; relock_b = 1'b0; status_b = 8'h00;
        #1;
        test_reset();
        test_timeout();
        test_lock_settle();
        test_settle_glitch();
        test_loss_relock();
        test_status();
        test_saturate();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
